// File: rtl/vga_frame_scheduler.sv
// ----------------------------------------------------------------------------
// vga_frame_scheduler
//   Owns the VGA raster position and shares the vertical-blanking update
//   window between NUM_REQ graphics requesters. Grants are issued
//   round-robin, at most one owner at a time and at most once per frame,
//   only during vblank. Each grant is limited to MAX_SLOT cycles.
//
// Ports
//   pixel_clk      pixel clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   req[N]         level request per requester
//   done[N]        requester finished (only honoured for the granted index)
//   x, y           current raster column / line
//   video_active   x < H_ACTIVE && y < V_ACTIVE
//   frame_start    high while x == 0 && y == 0
//   update_window  high on vblank lines (y >= V_ACTIVE)
//   grant[N]       one-hot or zero, owner of the update window
//   timeout        one-cycle pulse when a grant is revoked (budget/window end)
//   missed_count   requesters left unserved in the previous frame
//
// Build option
//   SCHED_STATS_EN  when defined, builds the unserved-requester counter that
//                   drives missed_count; otherwise missed_count is tied to 0.
// ----------------------------------------------------------------------------

// Per-requester bookkeeping: the "served this frame" bit and eligibility.
module vfs_req_lane (
  input  logic pixel_clk,
  input  logic reset,
  input  logic frame_clr,
  input  logic rel,
  input  logic gnt,
  input  logic req,
  output logic eligible
);
  logic served;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)            served <= 1'b0;
    else if (frame_clr)   served <= 1'b0;
    else if (rel && gnt)  served <= 1'b1;
  end

  assign eligible = req && !served;
endmodule

module vga_frame_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int NUM_REQ  = 4,
  parameter int MAX_SLOT = 64
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               video_active,
  output logic               frame_start,
  output logic               update_window,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout,
  output logic [7:0]         missed_count
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
  localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_SLOT - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NUM_REQ);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } raster_t;

  typedef enum logic {IDLE, GRANT} state_t;

  // --------------------------------------------------------------------------
  // Raster counters and decodes
  // --------------------------------------------------------------------------
  raster_t pos;
  logic    x_last, last_px;

  assign x_last  = (pos.x == H_LAST);
  assign last_px = x_last && (pos.y == V_LAST);

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else begin
      pos.x <= x_last ? 10'd0 : pos.x + 10'd1;
      if (x_last) pos.y <= (pos.y == V_LAST) ? 10'd0 : pos.y + 10'd1;
    end
  end

  assign x             = pos.x;
  assign y             = pos.y;
  assign video_active  = (pos.x < H_ACT) && (pos.y < V_ACT);
  assign frame_start   = (pos.x == 10'd0) && (pos.y == 10'd0);
  assign update_window = (pos.y >= V_ACT);

  // --------------------------------------------------------------------------
  // Requester lanes
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] eligible;
  logic               rel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    vfs_req_lane u_lane (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .frame_clr (frame_start),
      .rel       (rel),
      .gnt       (grant[i]),
      .req       (req[i]),
      .eligible  (eligible[i])
    );
  end

  // --------------------------------------------------------------------------
  // Round-robin pick: first eligible index at or after ptr, with wrap
  // --------------------------------------------------------------------------
  logic [PW-1:0] ptr, pick;
  logic          found;
  logic [PW:0]   rr_sum;

  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, ptr} + (PW+1)'(k);
      if (rr_sum >= NREQ_W) rr_sum = rr_sum - NREQ_W;
      if (!found && eligible[rr_sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = rr_sum[PW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM
  // --------------------------------------------------------------------------
  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [SW-1:0]      slot, slot_nxt;
  logic [PW-1:0]      ptr_nxt;
  logic               timeout_nxt;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      slot    <= '0;
      ptr     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      slot    <= slot_nxt;
      ptr     <= ptr_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    slot_nxt    = slot;
    ptr_nxt     = ptr;
    timeout_nxt = 1'b0;
    rel         = 1'b0;
    case (state)
      IDLE: begin
        // Not on the last vblank cycle: the grant would land on frame_start,
        // outside the window.
        if (update_window && !last_px && found) begin
          grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          slot_nxt  = '0;
          ptr_nxt   = (pick == PTR_LAST) ? '0 : pick + 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        slot_nxt = slot + 1'b1;
        // done wins over budget and window end, so no timeout in that case
        if (|(done & grant)) begin
          rel       = 1'b1;
          grant_nxt = '0;
          state_nxt = IDLE;
        end else if ((slot == SLOT_LAST) || last_px) begin
          rel         = 1'b1;
          grant_nxt   = '0;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Unserved-requester statistics
  // --------------------------------------------------------------------------
`ifdef SCHED_STATS_EN
  logic [NUM_REQ-1:0] miss_vec;
  logic [7:0]         miss_cnt, miss_acc, miss_q;
  logic [8:0]         acc_sum;

  // The current owner got the window this frame even though its served bit
  // is only set on the release edge.
  assign miss_vec = eligible & ~grant;

  always_comb begin
    miss_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) miss_cnt = miss_cnt + 8'(miss_vec[k]);
  end

  assign acc_sum = {1'b0, miss_acc} + {1'b0, miss_cnt};

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      miss_acc <= '0;
      miss_q   <= '0;
    end else if (frame_start) begin
      miss_q   <= miss_acc;
      miss_acc <= '0;
    end else if (last_px) begin
      miss_acc <= acc_sum[8] ? 8'hFF : acc_sum[7:0];
    end
  end

  assign missed_count = miss_q;
`else
  assign missed_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vga_frame_scheduler
//   Lockstep bench for vga_frame_scheduler with a small raster (20x12).
//   A cycle-level reference model derived from the scheduling rules (frame
//   position from a cycle count, owner/held-cycles bookkeeping) predicts every
//   output every cycle; each scenario task adds its own directed checks.
//   Define SCHED_STATS_EN to also exercise missed_count (budget then 40).
// ----------------------------------------------------------------------------
module tb_vga_frame_scheduler;
  localparam int HA = 16, HT = 20, VA = 10, VT = 12, NR = 4;
  localparam int FRAME = HT * VT;
`ifdef SCHED_STATS_EN
  localparam int MS = 40;
`else
  localparam int MS = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req, done;
  logic [9:0]    x, y;
  logic          va, fs, uw, to;
  logic [NR-1:0] grant;
  logic [7:0]    missed;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .NUM_REQ(NR), .MAX_SLOT(MS)
  ) dut (
    .pixel_clk(clk), .reset(rst), .req(req), .done(done),
    .x(x), .y(y), .video_active(va), .frame_start(fs), .update_window(uw),
    .grant(grant), .timeout(to), .missed_count(missed)
  );

  int ncmp = 0, nfail = 0;
  int cyc;

  // reference model state, describing the current cycle
  int      m_n, m_owner, m_held, m_ptr, m_acc, m_missed;
  bit [NR-1:0] m_served;
  bit      m_to;

  int g_cyc[$], g_idx[$], to_cyc[$];
  logic [NR-1:0] prev_g;

  task automatic model_reset();
    m_n = 0; m_owner = -1; m_held = 0; m_ptr = 0; m_acc = 0; m_missed = 0;
    m_served = '0; m_to = 1'b0;
    cyc = 0; prev_g = '0;
    g_cyc.delete(); g_idx.delete(); to_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = '0;
    @(posedge clk); #2;
    model_reset();
    rst = 1'b0;
  endtask

  // Advance one clock: predict the next cycle from the current inputs, then
  // compare every output against the prediction.
  task automatic tick();
    int py, o, h, p, acc, mis, ex, ey, j;
    bit [NR-1:0] sv;
    bit t;
    logic [NR-1:0] eg;
    logic [7:0] em;
    logic eva, efs, euw;
    py = m_n / HT;
    sv = m_served; o = m_owner; h = m_held; p = m_ptr; t = 1'b0;
    acc = m_acc; mis = m_missed;
    if (m_n == FRAME - 1)
      for (int k = 0; k < NR; k++)
        if (req[k] && !m_served[k] && m_owner != k) acc = (acc >= 255) ? 255 : acc + 1;
    if (m_n == 0) begin mis = acc; acc = 0; sv = '0; end
    if (m_owner >= 0) begin
      if (done[m_owner]) begin
        sv[m_owner] = 1'b1; o = -1;
      end else if (m_held == MS || m_n == FRAME - 1) begin
        sv[m_owner] = 1'b1; o = -1; t = 1'b1;
      end else h = m_held + 1;
    end else if (py >= VA && m_n != FRAME - 1) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (o < 0 && req[j] && !m_served[j]) begin o = j; h = 1; p = (j + 1) % NR; end
      end
    end
    @(posedge clk); #1;
    cyc++;
    m_n = (m_n + 1) % FRAME;
    m_served = sv; m_owner = o; m_held = h; m_ptr = p; m_to = t;
    m_acc = acc; m_missed = mis;

    ex = m_n % HT; ey = m_n / HT;
    eva = (ex < HA) && (ey < VA);
    efs = (m_n == 0);
    euw = (ey >= VA);
    eg  = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
`ifdef SCHED_STATS_EN
    em = 8'(m_missed);
`else
    em = 8'd0;
`endif
    ncmp++;
    if (x !== 10'(ex) || y !== 10'(ey)) begin
      nfail++; $display("FAIL raster cyc=%0d got x=%0d y=%0d want x=%0d y=%0d", cyc, x, y, ex, ey);
    end
    ncmp++;
    if ({va, fs, uw} !== {eva, efs, euw}) begin
      nfail++; $display("FAIL decode cyc=%0d got va/fs/uw=%b want %b", cyc, {va, fs, uw}, {eva, efs, euw});
    end
    ncmp++;
    if (grant !== eg) begin
      nfail++; $display("FAIL grant cyc=%0d got %b want %b", cyc, grant, eg);
    end
    ncmp++;
    if (to !== m_to) begin
      nfail++; $display("FAIL timeout cyc=%0d got %b want %b", cyc, to, m_to);
    end
    ncmp++;
    if (missed !== em) begin
      nfail++; $display("FAIL missed cyc=%0d got %0d want %0d", cyc, missed, em);
    end

    if (grant != '0 && prev_g == '0) begin
      g_cyc.push_back(cyc);
      for (int k = 0; k < NR; k++) if (grant[k]) g_idx.push_back(k);
    end
    if (to === 1'b1) to_cyc.push_back(cyc);
    prev_g = grant;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 4'b1111;
    @(posedge clk); #1;
    ncmp++;
    if (x !== 10'd0 || y !== 10'd0) begin
      nfail++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x, y);
    end
    ncmp++;
    if ({va, fs, uw} !== 3'b110) begin
      nfail++; $display("FAIL reset_decode got %b want 110", {va, fs, uw});
    end
    ncmp++;
    if (grant !== '0 || to !== 1'b0 || missed !== 8'd0) begin
      nfail++; $display("FAIL reset_grant got grant=%b to=%b missed=%0d want 0", grant, to, missed);
    end
    do_reset();
  endtask

  task automatic test_free_run();
    int first_uw, uw_cnt;
    do_reset();
    first_uw = -1; uw_cnt = 0;
    while (cyc < FRAME) begin
      tick();
      if (uw === 1'b1) begin
        uw_cnt++;
        if (first_uw < 0) first_uw = cyc;
      end
    end
    ncmp++;
    if (first_uw != 200 || uw_cnt != 40) begin
      nfail++; $display("FAIL vblank_span got first=%0d count=%0d want 200 40", first_uw, uw_cnt);
    end
    ncmp++;
    if (fs !== 1'b1 || y !== 10'd0) begin
      nfail++; $display("FAIL frame_wrap got fs=%b y=%0d want 1 0", fs, y);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    while (cyc < 260) begin
      done = '0;
      if (m_owner == 0 && m_held == 4) done[0] = 1'b1;
      tick();
    end
    ncmp++;
    if (g_cyc.size() != 1 || g_cyc[0] != 201) begin
      nfail++; $display("FAIL single_grant got count=%0d first=%0d want 1 201", g_cyc.size(),
                        (g_cyc.size() > 0) ? g_cyc[0] : -1);
    end
    ncmp++;
    if (to_cyc.size() != 0) begin
      nfail++; $display("FAIL single_timeout got %0d pulses want 0", to_cyc.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111;
    while (cyc < FRAME) begin
      done = '0;
      if (m_owner >= 0 && m_held == 3) done[m_owner] = 1'b1;
      tick();
    end
    ncmp++;
    if (g_cyc.size() != 4) begin
      nfail++; $display("FAIL rr_count got %0d want 4", g_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        ncmp++;
        if (g_idx[k] != k || g_cyc[k] != 201 + 4 * k) begin
          nfail++; $display("FAIL rr_order slot=%0d got idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                            k, g_idx[k], g_cyc[k], k, 201 + 4 * k);
        end
      end
    end
  endtask

  task automatic test_budget();
    int exp_to;
    do_reset();
    req = 4'b0010;
    exp_to = (200 + MS <= 239) ? 201 + MS : 240;
    while (cyc < 260) tick();
    ncmp++;
    if (g_cyc.size() != 1 || g_idx[0] != 1 || g_cyc[0] != 201) begin
      nfail++; $display("FAIL budget_grant got count=%0d want 1 grant of req1 at 201", g_cyc.size());
    end
    ncmp++;
    if (to_cyc.size() != 1 || to_cyc[0] != exp_to) begin
      nfail++; $display("FAIL budget_timeout got count=%0d at=%0d want 1 at %0d", to_cyc.size(),
                        (to_cyc.size() > 0) ? to_cyc[0] : -1, exp_to);
    end
  endtask

  task automatic test_window_end();
    do_reset();
    while (cyc < 450) begin
      req = (cyc >= 236) ? 4'b0100 : 4'b0000;
      tick();
    end
    ncmp++;
    if (g_cyc.size() != 2 || g_cyc[0] != 237 || g_cyc[1] != 441) begin
      nfail++; $display("FAIL window_grants got count=%0d want grants at 237 and 441", g_cyc.size());
    end
    ncmp++;
    if (to_cyc.size() < 1 || to_cyc[0] != 240) begin
      nfail++; $display("FAIL window_timeout got count=%0d first=%0d want first at 240", to_cyc.size(),
                        (to_cyc.size() > 0) ? to_cyc[0] : -1);
    end
  endtask

  task automatic test_random();
    do_reset();
    while (cyc < 3 * FRAME) begin
      if ($urandom_range(0, 7) == 0) req = NR'($urandom);
      done = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    while (cyc < 204) tick();
    rst = 1'b1;
    #1;
    ncmp++;
    if (grant !== '0 || to !== 1'b0 || x !== 10'd0 || y !== 10'd0) begin
      nfail++; $display("FAIL async_reset got grant=%b to=%b x=%0d y=%0d want 0", grant, to, x, y);
    end
    do_reset();
  endtask

`ifdef SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0011;
    while (cyc < 241) tick();
    ncmp++;
    if (missed !== 8'd1) begin
      nfail++; $display("FAIL stats_missed got %0d want 1", missed);
    end
    while (cyc < 445) tick();
    rst = 1'b1;
    #1;
    ncmp++;
    if (grant !== '0 || missed !== 8'd0 || to !== 1'b0) begin
      nfail++; $display("FAIL stats_reset got grant=%b missed=%0d to=%b want 0", grant, missed, to);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; done = '0;
    model_reset();
    test_reset();
    test_free_run();
    test_single();
    test_round_robin();
    test_budget();
    test_window_end();
    test_random();
    test_async_reset();
`ifdef SCHED_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
